mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage: consumes the registered EXE->MEM bundle, runs loads/stores on the data memory
//  over a req/ack handshake, and drives the registered MEM->WB bundle. Non-memory ops pass in 1 cycle.
//  It stalls upstream (Stall_OUT) while an access is outstanding. Memory is big-endian, 32-bit words.
// PARAMETERS
//  TIMEOUT  16      max cycles DMem_Req stays high without DMem_Ack before the access is aborted
//  OP_LB 6'h20 / OP_LBU 6'h24 / OP_LH 6'h21 / OP_LHU 6'h25 / OP_LW 6'h23   load size codes on ALU_Control
//  OP_SB 6'h28 / OP_SH 6'h29 / OP_SW 6'h2B                                 store size codes on ALU_Control
// PORTS
//  CLK                  in   1   clock; all state changes on posedge
//  RESET                in   1   asynchronous, active-high reset
//  Instr1_IN            in   32  instruction [debug]
//  Instr1_PC_IN         in   32  PC [debug]
//  ALU_result1_IN       in   32  ALU result; byte address for loads/stores
//  WriteRegister1_IN    in   5   destination register
//  MemWriteData1_IN     in   32  store data (right-justified for SB/SH)
//  RegWrite1_IN         in   1   op writes a register
//  ALU_Control1_IN      in   6   op code; selects access size/sign
//  MemRead1_IN          in   1   load
//  MemWrite1_IN         in   1   store (MemRead1_IN and MemWrite1_IN both high: treated as load)
//  DMem_Ack             in   1   memory completes the access this cycle
//  DMem_RData           in   32  read word, valid when DMem_Ack
//  Instr1_OUT           out  32  to WB [debug]
//  Instr1_PC_OUT        out  32  to WB [debug]
//  WriteData1_OUT       out  32  ALU result or extended load data
//  WriteRegister1_OUT   out  5   destination register
//  RegWrite1_OUT        out  1   WB writes WriteRegister1_OUT
//  DMem_Req             out  1   access request, held until ack or timeout
//  DMem_Write           out  1   1=store, 0=load
//  DMem_Addr            out  32  word-aligned address {addr[31:2],2'b00}
//  DMem_WData           out  32  store data replicated to lane positions
//  DMem_BE              out  4   byte enables; BE[3]=bits 31:24 = byte offset 0
//  Stall_OUT            out  1   upstream must hold its outputs this cycle
//  MemError_OUT         out  1   sticky: misaligned access or timeout
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. RESET mid-access drops DMem_Req immediately (async).
//  FSM IDLE:
//   - no mem op: register the bundle to outputs next edge (WriteData1_OUT=ALU_result1_IN). Stall_OUT=0.
//   - aligned mem op: latch bundle, go ACCESS. Stall_OUT=1 (comb). Outputs go bubble (RegWrite1_OUT=0).
//   - misaligned (half addr[0]=1, word addr[1:0]!=0): no request. Set MemError_OUT. Bubble out.
//     Stall_OUT=0. Stay IDLE.
//  FSM ACCESS: DMem_Req/Write/Addr/WData/BE registered from the latch, stable until exit.
//   - Stall_OUT = !DMem_Ack. Upstream inputs are ignored. Outputs stay bubble.
//   - DMem_Ack=1: go IDLE. Next edge registers the latched op to outputs.
//     Load: WriteData1_OUT = extended lane data, RegWrite1_OUT = latched RegWrite. Store: RegWrite1_OUT=0.
//     DMem_Req drops the same edge. No new op is accepted that edge; it is accepted next cycle.
//   - counter reaches TIMEOUT with no ack: drop Req, set MemError_OUT, bubble out, go IDLE. Late acks ignored.
//  Latency: non-mem 1 edge. Mem op: accepted at edge E, Req high after E, ack at cycle k -> result at edge k+1.
//   Minimum 2 edges.
//  Lanes: offset o=addr[1:0].
//   - Byte: BE=4'b1000>>o, WData={4{d[7:0]}}, data=RData[31-8o -: 8].
//   - Half: BE=o[1]?0011:1100, WData={2{d[15:0]}}.
//   - Word: BE=1111.
//   - LB/LH sign-extend; LBU/LHU zero-extend. Unknown size code with a mem op = word.
//  MemError_OUT clears only on RESET.
// TESTING
//  ADD bundle, ALU_result1=0x1234, RegWrite=1, reg 5 -> next edge WriteData1_OUT=0x1234, RegWrite1_OUT=1,
//   Stall_OUT=0 throughout.
//  LW addr 0x100, Ack 3 cycles after Req, RData=0xDEADBEEF -> Stall 4 cycles, DMem_Addr=0x100, BE=1111,
//   then WriteData1_OUT=0xDEADBEEF.
//  LB addr 0x103, RData=0x000000F0 -> BE read lane 3, WriteData1_OUT=0xFFFFFFF0. LBU same -> 0x000000F0.
//  SH addr 0x202, data 0xABCD1234 -> BE=0011, WData=0x12341234, DMem_Write=1, RegWrite1_OUT=0 on completion.
//  LW addr 0x101 -> no DMem_Req, MemError_OUT=1, RegWrite1_OUT=0. Then ADD passes normally next cycle.
//  LW never acked -> Req drops after TIMEOUT=16 cycles, MemError_OUT=1, Stall released. RESET mid-access
//   -> all outputs 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes non-memory ops through in one cycle, runs
// loads/stores on a big-endian 32-bit data memory over a req/ack handshake,
// and stalls upstream while an access is outstanding.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [5:0]  OP_LB   = 6'h20,
  parameter logic [5:0]  OP_LBU  = 6'h24,
  parameter logic [5:0]  OP_LH   = 6'h21,
  parameter logic [5:0]  OP_LHU  = 6'h25,
  parameter logic [5:0]  OP_LW   = 6'h23,
  parameter logic [5:0]  OP_SB   = 6'h28,
  parameter logic [5:0]  OP_SH   = 6'h29,
  parameter logic [5:0]  OP_SW   = 6'h2B
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic        DMem_Ack,
  input  logic [31:0] DMem_RData,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        DMem_Req,
  output logic        DMem_Write,
  output logic [31:0] DMem_Addr,
  output logic [31:0] DMem_WData,
  output logic [3:0]  DMem_BE,
  output logic        Stall_OUT,
  output logic        MemError_OUT
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;

  // Latched op held for the duration of an access
  logic [31:0] lat_instr;
  logic [31:0] lat_pc;
  logic [31:0] lat_addr;
  logic [4:0]  lat_wreg;
  logic        lat_regwrite;
  logic        lat_load;
  size_t       lat_size;
  logic        lat_signed;

  // Decode of the incoming bundle
  logic        in_mem;
  size_t       in_size;
  logic        in_signed;
  logic        in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [1:0]  in_off;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        tmo_hit;

  assign in_off  = ALU_result1_IN[1:0];
  assign in_mem  = MemRead1_IN | MemWrite1_IN;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1)) && !DMem_Ack;

  // Decode access size, sign, alignment and lane placement of the input op
  always_comb begin
    in_size   = SZ_WORD;
    in_signed = 1'b0;
    case (ALU_Control1_IN)
      OP_LB:        begin in_size = SZ_BYTE; in_signed = 1'b1; end
      OP_LBU:       in_size = SZ_BYTE;
      OP_LH:        begin in_size = SZ_HALF; in_signed = 1'b1; end
      OP_LHU:       in_size = SZ_HALF;
      OP_SB:        in_size = SZ_BYTE;
      OP_SH:        in_size = SZ_HALF;
      OP_LW, OP_SW: in_size = SZ_WORD;
      default:      in_size = SZ_WORD;
    endcase

    in_misaligned = 1'b0;
    in_be         = 4'b1111;
    in_wdata      = MemWriteData1_IN;
    case (in_size)
      SZ_BYTE: begin
        in_be    = 4'b1000 >> in_off;
        in_wdata = {4{MemWriteData1_IN[7:0]}};
      end
      SZ_HALF: begin
        in_misaligned = in_off[0];
        in_be         = in_off[1] ? 4'b0011 : 4'b1100;
        in_wdata      = {2{MemWriteData1_IN[15:0]}};
      end
      default: in_misaligned = (in_off != 2'b00);
    endcase
  end

  // Select and extend the addressed lane of the returned read word
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    rd_byte = DMem_RData[31:24];
      2'd1:    rd_byte = DMem_RData[23:16];
      2'd2:    rd_byte = DMem_RData[15:8];
      default: rd_byte = DMem_RData[7:0];
    endcase
    rd_half = lat_addr[1] ? DMem_RData[15:0] : DMem_RData[31:16];
    case (lat_size)
      SZ_BYTE: rd_ext = {{24{lat_signed & rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_ext = {{16{lat_signed & rd_half[15]}}, rd_half};
      default: rd_ext = DMem_RData;
    endcase
  end

  // Upstream stall: while accepting an access and until it completes or times out
  always_comb begin
    Stall_OUT = 1'b0;
    case (state)
      IDLE:    Stall_OUT = in_mem & !in_misaligned;
      ACCESS:  Stall_OUT = !(DMem_Ack || tmo_hit);
      default: Stall_OUT = 1'b0;
    endcase
  end

  // Stage FSM: output bundle, memory request and error flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state              <= IDLE;
      tmo_cnt            <= '0;
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      WriteData1_OUT     <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT      <= 1'b0;
      DMem_Req           <= 1'b0;
      DMem_Write         <= 1'b0;
      DMem_Addr          <= '0;
      DMem_WData         <= '0;
      DMem_BE            <= '0;
      MemError_OUT       <= 1'b0;
      lat_instr          <= '0;
      lat_pc             <= '0;
      lat_addr           <= '0;
      lat_wreg           <= '0;
      lat_regwrite       <= 1'b0;
      lat_load           <= 1'b0;
      lat_size           <= SZ_WORD;
      lat_signed         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_mem) begin
            Instr1_OUT         <= '0;
            Instr1_PC_OUT      <= '0;
            WriteData1_OUT     <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            if (in_misaligned) begin
              MemError_OUT <= 1'b1;
            end else begin
              lat_instr    <= Instr1_IN;
              lat_pc       <= Instr1_PC_IN;
              lat_addr     <= ALU_result1_IN;
              lat_wreg     <= WriteRegister1_IN;
              lat_regwrite <= RegWrite1_IN;
              lat_load     <= MemRead1_IN;
              lat_size     <= in_size;
              lat_signed   <= in_signed;
              DMem_Req     <= 1'b1;
              DMem_Write   <= !MemRead1_IN;
              DMem_Addr    <= {ALU_result1_IN[31:2], 2'b00};
              DMem_WData   <= in_wdata;
              DMem_BE      <= in_be;
              tmo_cnt      <= '0;
              state        <= ACCESS;
            end
          end else begin
            Instr1_OUT         <= Instr1_IN;
            Instr1_PC_OUT      <= Instr1_PC_IN;
            WriteData1_OUT     <= ALU_result1_IN;
            WriteRegister1_OUT <= WriteRegister1_IN;
            RegWrite1_OUT      <= RegWrite1_IN;
          end
        end
        ACCESS: begin
          if (DMem_Ack || tmo_hit) begin
            DMem_Req   <= 1'b0;
            DMem_Write <= 1'b0;
            DMem_Addr  <= '0;
            DMem_WData <= '0;
            DMem_BE    <= '0;
            state      <= IDLE;
          end
          if (DMem_Ack) begin
            Instr1_OUT         <= lat_instr;
            Instr1_PC_OUT      <= lat_pc;
            WriteData1_OUT     <= lat_load ? rd_ext : lat_addr;
            WriteRegister1_OUT <= lat_wreg;
            RegWrite1_OUT      <= lat_load & lat_regwrite;
          end else if (tmo_hit) begin
            MemError_OUT <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs and
// memory requests; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        DMem_Ack;
  logic [31:0] DMem_RData;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic [4:0]  WriteRegister1_OUT;
  logic        RegWrite1_OUT, DMem_Req, DMem_Write;
  logic [31:0] DMem_Addr, DMem_WData;
  logic [3:0]  DMem_BE;
  logic        Stall_OUT, MemError_OUT;

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  int   checks = 0;
  int   errors = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN), .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .DMem_Req(DMem_Req), .DMem_Write(DMem_Write),
    .DMem_Addr(DMem_Addr), .DMem_WData(DMem_WData), .DMem_BE(DMem_BE),
    .Stall_OUT(Stall_OUT), .MemError_OUT(MemError_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare completed handshakes and write-backs against the scoreboard
  always @(negedge CLK) begin
    if (!RESET && DMem_Req && DMem_Ack) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %h expected none", DMem_Addr);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        chk("req_write", {31'd0, DMem_Write}, {31'd0, r.wr});
        chk("req_addr", DMem_Addr, r.addr);
        chk("req_wdata", DMem_WData, r.wdata);
        chk("req_be", {28'd0, DMem_BE}, {28'd0, r.be});
      end
    end
    if (!RESET && RegWrite1_OUT) begin
      if (exp_wb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wb: got reg %0d data %h expected none", WriteRegister1_OUT, WriteData1_OUT);
      end else begin
        wb_t w;
        w = exp_wb.pop_front();
        chk("wb_reg", {27'd0, WriteRegister1_OUT}, {27'd0, w.wreg});
        chk("wb_data", WriteData1_OUT, w.data);
      end
    end
  end

  task automatic drive(input logic [31:0] alu, input logic [4:0] wreg, input logic [31:0] wd,
                       input logic rw, input logic [5:0] ctl, input logic mr, input logic mw);
    Instr1_IN         = 32'hC0DE_0000 | {26'd0, ctl};
    Instr1_PC_IN      = alu ^ 32'h0000_1000;
    ALU_result1_IN    = alu;
    WriteRegister1_IN = wreg;
    MemWriteData1_IN  = wd;
    RegWrite1_IN      = rw;
    ALU_Control1_IN   = ctl;
    MemRead1_IN       = mr;
    MemWrite1_IN      = mw;
  endtask

  task automatic nop();
    drive(32'd0, 5'd0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  // Acts as the stalled upstream and the memory: holds the op, acks after 'delay' Req cycles
  task automatic run_access(input int delay, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    @(negedge CLK); if (Stall_OUT) stalls++;
    @(posedge CLK); #1;
    repeat (delay) begin
      @(negedge CLK); if (Stall_OUT) stalls++;
      @(posedge CLK); #1;
    end
    DMem_Ack = 1'b1; DMem_RData = rdata;
    @(negedge CLK); if (Stall_OUT) stalls++;
    @(posedge CLK); #1;
    DMem_Ack = 1'b0; DMem_RData = '0;
    nop();
  endtask

  task automatic do_load(input string nm, input logic [31:0] addr, input logic [5:0] ctl,
                         input logic [4:0] wreg, input int delay, input logic [31:0] rdata,
                         input logic [3:0] be, input logic [31:0] exp_data);
    int st;
    drive(addr, wreg, 32'd0, 1'b1, ctl, 1'b1, 1'b0);
    exp_req.push_back('{wr: 1'b0, addr: {addr[31:2], 2'b00}, wdata: 32'd0, be: be});
    exp_wb.push_back('{wreg: wreg, data: exp_data});
    run_access(delay, rdata, st);
    chk({nm, "_stall_cycles"}, st, delay + 1);
  endtask

  task automatic do_store(input string nm, input logic [31:0] addr, input logic [5:0] ctl,
                          input logic [31:0] data, input logic [3:0] be, input logic [31:0] wdata);
    int st;
    drive(addr, 5'd4, data, 1'b0, ctl, 1'b0, 1'b1);
    exp_req.push_back('{wr: 1'b1, addr: {addr[31:2], 2'b00}, wdata: wdata, be: be});
    run_access(0, 32'd0, st);
    chk({nm, "_stall_cycles"}, st, 1);
    @(negedge CLK);
    chk({nm, "_regwrite"}, {31'd0, RegWrite1_OUT}, 32'd0);
    chk({nm, "_req_dropped"}, {31'd0, DMem_Req}, 32'd0);
  endtask

  initial begin
    int reqcnt;
    bit done;
    nop();
    DMem_Ack = 1'b0; DMem_RData = '0;
    #2 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_wdata", WriteData1_OUT, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
    chk("rst_req", {31'd0, DMem_Req}, 32'd0);
    chk("rst_stall", {31'd0, Stall_OUT}, 32'd0);
    chk("rst_memerr", {31'd0, MemError_OUT}, 32'd0);
    chk("rst_instr", Instr1_OUT, 32'd0);
    @(posedge CLK); #1 RESET = 1'b0;

    // ADD passes in one edge
    drive(32'h1234, 5'd5, 32'd0, 1'b1, 6'h00, 1'b0, 1'b0);
    exp_wb.push_back('{wreg: 5'd5, data: 32'h1234});
    @(negedge CLK); chk("add_stall", {31'd0, Stall_OUT}, 32'd0);
    @(posedge CLK); #1 nop();
    @(negedge CLK); chk("add_stall2", {31'd0, Stall_OUT}, 32'd0);
    chk("add_instr_out", Instr1_OUT, 32'hC0DE_0000);
    @(posedge CLK); #1;

    // Loads: word, bytes, halves
    do_load("lw",  32'h100, 6'h23, 5'd6,  3, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",  32'h103, 6'h20, 5'd7,  1, 32'h0000_00F0, 4'b0001, 32'hFFFF_FFF0);
    do_load("lbu", 32'h103, 6'h24, 5'd8,  0, 32'h0000_00F0, 4'b0001, 32'h0000_00F0);
    do_load("lb1", 32'h101, 6'h20, 5'd9,  0, 32'h1180_2233, 4'b0100, 32'hFFFF_FF80);
    do_load("lh",  32'h102, 6'h21, 5'd10, 0, 32'h1234_8001, 4'b0011, 32'hFFFF_8001);
    do_load("lhu", 32'h100, 6'h25, 5'd11, 2, 32'h8001_0000, 4'b1100, 32'h0000_8001);

    // Stores
    do_store("sh", 32'h202, 6'h29, 32'hABCD_1234, 4'b0011, 32'h1234_1234);
    do_store("sb", 32'h201, 6'h28, 32'h0000_005A, 4'b0100, 32'h5A5A_5A5A);
    chk("no_err_yet", {31'd0, MemError_OUT}, 32'd0);
    @(posedge CLK); #1;

    // Timeout: never acked
    drive(32'h300, 5'd12, 32'd0, 1'b1, 6'h23, 1'b1, 1'b0);
    reqcnt = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (DMem_Req) reqcnt++;
      if (reqcnt == 1 && DMem_Req) chk("tmo_addr", DMem_Addr, 32'h300);
      if (!Stall_OUT) done = 1;
      @(posedge CLK); #1;
    end
    nop();
    chk("tmo_bounded", {31'd0, done}, 32'd1);
    chk("tmo_req_cycles", reqcnt, 16);
    @(negedge CLK);
    chk("tmo_req_low", {31'd0, DMem_Req}, 32'd0);
    chk("tmo_memerr", {31'd0, MemError_OUT}, 32'd1);
    chk("tmo_stall", {31'd0, Stall_OUT}, 32'd0);
    chk("tmo_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);

    // Reset clears sticky error; then misaligned LW followed by ADD
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    chk("rst_clears_err", {31'd0, MemError_OUT}, 32'd0);
    drive(32'h101, 5'd3, 32'd0, 1'b1, 6'h23, 1'b1, 1'b0);
    @(negedge CLK);
    chk("mis_stall", {31'd0, Stall_OUT}, 32'd0);
    @(posedge CLK); #1;
    drive(32'h55, 5'd13, 32'd0, 1'b1, 6'h00, 1'b0, 1'b0);
    exp_wb.push_back('{wreg: 5'd13, data: 32'h55});
    @(negedge CLK);
    chk("mis_memerr", {31'd0, MemError_OUT}, 32'd1);
    chk("mis_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
    chk("mis_req", {31'd0, DMem_Req}, 32'd0);
    @(posedge CLK); #1 nop();
    @(negedge CLK);
    @(posedge CLK); #1;

    // Reset in the middle of an access
    drive(32'h400, 5'd14, 32'd0, 1'b1, 6'h23, 1'b1, 1'b0);
    @(posedge CLK); #1;
    @(negedge CLK); chk("mid_req_up", {31'd0, DMem_Req}, 32'd1);
    @(posedge CLK); #3;
    RESET = 1'b1; nop();
    #1;
    chk("mid_rst_req", {31'd0, DMem_Req}, 32'd0);
    chk("mid_rst_stall", {31'd0, Stall_OUT}, 32'd0);
    chk("mid_rst_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
    chk("mid_rst_wdata", WriteData1_OUT, 32'd0);
    chk("mid_rst_memerr", {31'd0, MemError_OUT}, 32'd0);
    chk("mid_rst_be", {28'd0, DMem_BE}, 32'd0);
    @(posedge CLK); #1 RESET = 1'b0;

    repeat (3) @(posedge CLK);
    chk("wb_queue_empty", exp_wb.size(), 0);
    chk("req_queue_empty", exp_req.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
